// File: rtl/bcd_digit_entry_pkg.sv
// Shared definitions for the BCD digit-entry block: FSM encoding and digit sizing.
package bcd_digit_entry_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned MAX_DIGITS = 3;

    // A nibble is a legal BCD digit when it is 0..9.
    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return d <= BCD_W'(9);
    endfunction

endpackage

// File: rtl/bcd_digit_entry_idle_timer.sv
// Idle timer for the entry FSM: counts cycles without an accepted digit while running.
module bcd_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic kick,
    input  logic clr,
    output logic expired
);

    if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_cnt_w_check
        $error("bcd_idle_timer: CNT_W too small for TIMEOUT_CYCLES");
    end

    logic [CNT_W-1:0] cnt;

    // Counter: zero when stopped, cleared or kicked; otherwise count up, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !run || kick) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Expiry decode; a zero timeout disables it entirely.
    always_comb begin
        expired = (TIMEOUT_CYCLES != 0) && run && (cnt == CNT_W'(TIMEOUT_CYCLES));
    end

endmodule

// File: rtl/bcd_digit_entry.sv
// Keypad-style BCD entry: collects up to three digits MSD first, commits on enter,
// holds the number until the consumer takes it.
module bcd_digit_entry
    import bcd_digit_entry_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BCD_W-1:0] digit_in,
    input  logic             digit_valid,
    output logic             digit_ready,
    input  logic             enter,
    input  logic             clear,
    output logic [BCD_W-1:0] huns,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] units,
    output logic             bcd_valid,
    input  logic             out_ready,
    output logic [1:0]       digit_cnt,
    output logic             err
);

    state_t           state, state_n;
    logic [BCD_W-1:0] huns_n, tens_n, units_n;
    logic [1:0]       cnt_n;
    logic             err_n;
    logic             ready_q, ready_n;
    logic             accept;
    logic             expired;

    bcd_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state == COLLECT),
        .kick   (accept && (state == COLLECT)),
        .clr    (clear),
        .expired(expired)
    );

    // digit_ready is a register computed from next state, so it is 0 throughout
    // reset and rises on the first edge after release without an input-to-output path.
    assign accept      = digit_valid && ready_q;
    assign digit_ready = ready_q;
    assign bcd_valid   = (state == HOLD);

    // Next-state and datapath update; clear/timeout override everything.
    always_comb begin
        state_n = state;
        huns_n  = huns;
        tens_n  = tens;
        units_n = units;
        cnt_n   = digit_cnt;
        err_n   = err;

        if (clear || expired) begin
            state_n = IDLE;
            huns_n  = '0;
            tens_n  = '0;
            units_n = '0;
            cnt_n   = '0;
            err_n   = 1'b0;
        end else begin
            unique case (state)
                IDLE, COLLECT: begin
                    if (accept) begin
                        if (is_bcd(digit_in)) begin
                            huns_n  = tens;
                            tens_n  = units;
                            units_n = digit_in;
                            cnt_n   = digit_cnt + 2'd1;
                            state_n = COLLECT;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    // Digit is taken first, so a same-cycle commit includes it.
                    if (enter) begin
                        if (state == IDLE || cnt_n == 2'd0) begin
                            err_n = 1'b1;
                        end else begin
                            state_n = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_n = IDLE;
                        huns_n  = '0;
                        tens_n  = '0;
                        units_n = '0;
                        cnt_n   = '0;
                        err_n   = 1'b0;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        ready_n = (state_n != HOLD) && (cnt_n < 2'(MAX_DIGITS));
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            huns      <= '0;
            tens      <= '0;
            units     <= '0;
            digit_cnt <= '0;
            err       <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state     <= state_n;
            huns      <= huns_n;
            tens      <= tens_n;
            units     <= units_n;
            digit_cnt <= cnt_n;
            err       <= err_n;
            ready_q   <= ready_n;
        end
    end

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Directed self-checking bench for bcd_digit_entry (TIMEOUT_CYCLES = 8).
module tb_bcd_digit_entry;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       digit_ready;
    logic       enter;
    logic       clear;
    logic [3:0] huns, tens, units;
    logic       bcd_valid;
    logic       out_ready;
    logic [1:0] digit_cnt;
    logic       err;

    int unsigned total  = 0;
    int unsigned passed = 0;

    bcd_digit_entry #(
        .TIMEOUT_CYCLES(8),
        .CNT_W         (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_in   (digit_in),
        .digit_valid(digit_valid),
        .digit_ready(digit_ready),
        .enter      (enter),
        .clear      (clear),
        .huns       (huns),
        .tens       (tens),
        .units      (units),
        .bcd_valid  (bcd_valid),
        .out_ready  (out_ready),
        .digit_cnt  (digit_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // One clock edge, then return on the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put_digit(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
    endtask

    task automatic check_digits(input string tag, input logic [3:0] h, input logic [3:0] t,
                                input logic [3:0] u);
        check({tag, "_huns"},  {4'd0, huns},  {4'd0, h});
        check({tag, "_tens"},  {4'd0, tens},  {4'd0, t});
        check({tag, "_units"}, {4'd0, units}, {4'd0, u});
    endtask

    initial begin
        rst_n = 1'b0; digit_in = '0; digit_valid = 1'b0;
        enter = 1'b0; clear = 1'b0; out_ready = 1'b0;
        #2;
        check("rst_ready", {7'd0, digit_ready}, 8'd0);
        check("rst_valid", {7'd0, bcd_valid}, 8'd0);
        check("rst_cnt",   {6'd0, digit_cnt}, 8'd0);
        check("rst_err",   {7'd0, err}, 8'd0);
        check_digits("rst", 4'd0, 4'd0, 4'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {7'd0, digit_ready}, 8'd1);

        // 2,0,0 then enter, then handshake
        put_digit(4'd2);
        check("d2_units", {4'd0, units}, 8'd2);
        check("d2_cnt", {6'd0, digit_cnt}, 8'd1);
        put_digit(4'd0);
        put_digit(4'd0);
        check_digits("d200", 4'd2, 4'd0, 4'd0);
        check("d200_ready", {7'd0, digit_ready}, 8'd0);
        enter = 1'b1; step(); enter = 1'b0;
        check("c200_valid", {7'd0, bcd_valid}, 8'd1);
        check_digits("c200", 4'd2, 4'd0, 4'd0);
        digit_in = 4'd7; digit_valid = 1'b1; enter = 1'b1; step();
        digit_valid = 1'b0; enter = 1'b0;
        check_digits("hold_frozen", 4'd2, 4'd0, 4'd0);
        check("hold_ready", {7'd0, digit_ready}, 8'd0);
        check("hold_valid", {7'd0, bcd_valid}, 8'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("hs_valid", {7'd0, bcd_valid}, 8'd0);
        check("hs_cnt", {6'd0, digit_cnt}, 8'd0);
        check("hs_ready", {7'd0, digit_ready}, 8'd1);
        check_digits("hs", 4'd0, 4'd0, 4'd0);

        // 9,9,9 then a 4th digit held valid
        put_digit(4'd9); put_digit(4'd9); put_digit(4'd9);
        digit_in = 4'd5; digit_valid = 1'b1;
        step(); step();
        check("d4_ready", {7'd0, digit_ready}, 8'd0);
        check("d4_cnt", {6'd0, digit_cnt}, 8'd3);
        check_digits("d4", 4'd9, 4'd9, 4'd9);
        enter = 1'b1; step(); enter = 1'b0; digit_valid = 1'b0;
        check("c999_valid", {7'd0, bcd_valid}, 8'd1);
        check_digits("c999", 4'd9, 4'd9, 4'd9);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // 5 then 9 together with enter
        put_digit(4'd5);
        digit_in = 4'd9; digit_valid = 1'b1; enter = 1'b1;
        step();
        digit_valid = 1'b0; enter = 1'b0;
        check("c59_valid", {7'd0, bcd_valid}, 8'd1);
        check("c59_cnt", {6'd0, digit_cnt}, 8'd2);
        check_digits("c59", 4'd0, 4'd5, 4'd9);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Non-BCD digit
        put_digit(4'd3);
        put_digit(4'hC);
        check("nbcd_err", {7'd0, err}, 8'd1);
        check("nbcd_cnt", {6'd0, digit_cnt}, 8'd1);
        check("nbcd_units", {4'd0, units}, 8'd3);
        clear = 1'b1; step(); clear = 1'b0;
        check("clr_err", {7'd0, err}, 8'd0);
        check("clr_cnt", {6'd0, digit_cnt}, 8'd0);
        check("clr_units", {4'd0, units}, 8'd0);

        // Enter with no digits
        enter = 1'b1; step(); enter = 1'b0;
        check("empty_err", {7'd0, err}, 8'd1);
        check("empty_valid", {7'd0, bcd_valid}, 8'd0);
        check("empty_ready", {7'd0, digit_ready}, 8'd1);
        put_digit(4'd1);
        check("sticky_err", {7'd0, err}, 8'd1);
        clear = 1'b1; step(); clear = 1'b0;

        // Timeout: 6 then a bad digit (sets err, restarts the idle count), then idle
        put_digit(4'd6);
        put_digit(4'hF);
        check("to_err_set", {7'd0, err}, 8'd1);
        repeat (8) step();
        check("to_before_cnt", {6'd0, digit_cnt}, 8'd1);
        step();
        check("to_cnt", {6'd0, digit_cnt}, 8'd0);
        check("to_err", {7'd0, err}, 8'd0);
        check("to_units", {4'd0, units}, 8'd0);
        check("to_ready", {7'd0, digit_ready}, 8'd1);

        // Clear in HOLD
        put_digit(4'd4);
        enter = 1'b1; step(); enter = 1'b0;
        check("ch_valid_pre", {7'd0, bcd_valid}, 8'd1);
        clear = 1'b1; step(); clear = 1'b0;
        check("ch_valid", {7'd0, bcd_valid}, 8'd0);
        check("ch_units", {4'd0, units}, 8'd0);

        // Asynchronous reset mid-entry
        put_digit(4'd1); put_digit(4'd2);
        check("ar_pre_units", {4'd0, units}, 8'd2);
        rst_n = 1'b0;
        #1;
        check_digits("ar", 4'd0, 4'd0, 4'd0);
        check("ar_cnt", {6'd0, digit_cnt}, 8'd0);
        check("ar_ready", {7'd0, digit_ready}, 8'd0);
        #1;
        rst_n = 1'b1;
        step();
        check("ar_post_ready", {7'd0, digit_ready}, 8'd1);
        check("ar_post_cnt", {6'd0, digit_cnt}, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bcd_digit_entry.md
BCD_DIGIT_ENTRY -- requirements
Module: bcd_digit_entry

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning idle cycles in COLLECT before auto-clear; 0 disables the timeout.
REQ-002 SHALL have parameter CNT_W, default 10, meaning the timeout counter width; it SHALL be at least clog2(TIMEOUT_CYCLES+1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port digit_in, input, 4 bits: incoming BCD digit, most significant digit entered first.
REQ-006 SHALL have port digit_valid, input, 1 bit: digit_in is valid this cycle.
REQ-007 SHALL have port digit_ready, output, 1 bit: the block can accept a digit this cycle.
REQ-008 SHALL have port enter, input, 1 bit: single-cycle commit request.
REQ-009 SHALL have port clear, input, 1 bit: single-cycle abort request.
REQ-010 SHALL have ports huns, tens and units, each output, 4 bits: registered BCD digits that feed the BCD-to-binary converter directly.
REQ-011 SHALL have port bcd_valid, output, 1 bit: huns/tens/units hold a committed number.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the committed number.
REQ-013 SHALL have port digit_cnt, output, 2 bits: number of digits held, 0 to 3.
REQ-014 SHALL have port err, output, 1 bit: sticky error flag for a non-BCD digit or a rejected commit.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT and HOLD.
REQ-016 A digit SHALL be accepted on a cycle where digit_valid=1 and digit_ready=1.
REQ-017 digit_ready SHALL be 1 only in IDLE or COLLECT with digit_cnt<3.
REQ-018 Accepting a digit with value 0–9 SHALL shift the digits (huns<=tens, tens<=units, units<=digit_in), increment digit_cnt, and move to COLLECT.
REQ-019 Accepting a digit with value 10–15 SHALL be consumed: digits and digit_cnt unchanged, err set to 1, state unchanged.
REQ-020 Leading positions not yet entered SHALL read 0 (example: entering 6 then 4 gives huns=0, tens=6, units=4).
REQ-021 enter in COLLECT SHALL move the FSM to HOLD on the next edge.
REQ-022 In HOLD, bcd_valid SHALL be 1 and the digits SHALL be frozen.
REQ-023 enter in IDLE, or while digit_cnt=0, SHALL be ignored and SHALL set err.
REQ-024 Same-cycle digit accept and enter SHALL take the digit first, then commit; the committed value includes that digit.
REQ-025 In HOLD with out_ready=1, the FSM SHALL return to IDLE: digits zeroed, digit_cnt=0, bcd_valid=0 on the next edge.
REQ-026 In HOLD, digit_valid and enter SHALL be ignored; digit_ready SHALL be 0.
REQ-027 clear SHALL have the highest priority in any state: next state IDLE, digits 0, digit_cnt 0, err 0, timeout counter 0.
REQ-028 This holds even in HOLD; bcd_valid then drops without a handshake.
REQ-029 When the 4th digit is offered, digit_ready=0: the digit is not taken and the held state is unchanged.
REQ-030 In COLLECT, the timeout counter SHALL reset on any accepted digit and increment otherwise.
REQ-031 When the counter reaches TIMEOUT_CYCLES, the block SHALL behave as a clear on the next edge (err also cleared).
REQ-032 The timeout counter SHALL be held at 0 outside COLLECT.
REQ-033 err SHALL clear only on clear, timeout, reset, or the HOLD->IDLE handshake.
REQ-034 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from inputs to outputs.
REQ-035 Latency from an accepted digit to the updated digits, and from enter to bcd_valid, SHALL each be 1 cycle.

Reset
REQ-036 While rst_n=0, all outputs and state SHALL go immediately to: IDLE, huns=tens=units=0, digit_cnt=0, bcd_valid=0, err=0, counter=0.
REQ-037 While rst_n=0, digit_ready SHALL be 0.
REQ-038 Reset asserted mid-entry or in HOLD SHALL discard all data with no handshake.
REQ-039 On the first edge after rst_n deasserts, the state SHALL be IDLE with digit_ready=1.

Structure
REQ-040 A shared package SHALL hold the FSM state encoding (IDLE, COLLECT, HOLD), the BCD digit width constant 4, and the maximum digit count 3.
REQ-041 One sub-module, bcd_idle_timer, SHALL hold the timeout counter, with inputs clk, rst_n, run, kick, clr and output expired.
REQ-042 The datapath and FSM SHALL stay in the top module.

Verification
REQ-043 Digits 2,0,0 then enter -> bcd_valid=1 with huns=2, tens=0, units=0; out_ready=1 -> IDLE, outputs 0.
REQ-044 Digits 9,9,9, then a 4th digit 5 held valid -> digit_ready=0 and the digits stay 9,9,9; enter -> commit 999.
REQ-045 Digit 9 presented with enter in the same cycle, after 5 -> commit tens=5, units=9.
REQ-046 Digit 12 (0xC) -> err=1 and digit_cnt unchanged.
REQ-047 enter with no digits -> err=1 and state stays IDLE.
REQ-048 With TIMEOUT_CYCLES=8: enter digit 6, then idle 8 cycles -> auto-clear, digit_cnt=0.
REQ-049 Clear in HOLD -> bcd_valid drops the next cycle.
REQ-050 rst_n pulsed low after 2 digits -> outputs 0 immediately, before any clock edge.
